sr_cmd_conditioner: RTL and testbench
=====================================

// Module: sr_cmd_conditioner
// PURPOSE
//   Upstream stage of the D-flop based SR flip-flop (sr_using_d).
//   Takes raw asynchronous set/reset requests (buttons, external lines), then:
//     - synchronises each one;
//     - debounces each one;
//     - edge-detects each one into a one-cycle s/r command pulse.
//   Arbitrates simultaneous requests, so the forbidden s=r=1 input is never presented downstream.
//   s/r connect directly to the SR flop's s/r inputs, on the same clk.
// PARAMETERS
//   DEBOUNCE_CYCLES  4  consecutive cycles a synchronised level must hold before it is accepted (>=1)
//   CNT_W            3  width of each debounce counter; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
//   COLL_W           8  width of the collision counter
//   RESET_WINS       1  collision winner: 1 = r issued and s dropped; 0 = s issued and r dropped
// PORTS
//   clk            in   1       system clock, rising-edge
//   rst            in   1       asynchronous, active-high reset
//   set_in         in   1       raw set request, asynchronous to clk
//   reset_in       in   1       raw reset request, asynchronous to clk
//   s              out  1       one-cycle set command to SR flop
//   r              out  1       one-cycle reset command to SR flop
//   set_db         out  1       debounced level of set_in
//   reset_db       out  1       debounced level of reset_in
//   collision      out  1       one-cycle flag: both edges arrived in the same cycle
//   collision_cnt  out  COLL_W  saturating count of collisions
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - all flops clear; s=r=0, set_db=reset_db=0, collision=0, collision_cnt=0;
//     - sync chains and debounce counters clear.
//   Sync: each input passes through a 2-flop synchroniser (stages sync1 -> sync2).
//   Debounce, per channel:
//     - if sync2 != *_db: counter increments;
//     - when the counter reaches DEBOUNCE_CYCLES: *_db takes sync2 on that edge and the counter clears;
//     - if sync2 == *_db: counter clears (a glitch shorter than DEBOUNCE_CYCLES is rejected).
//   Edge detect: rise_* = *_db & ~*_db_d (registered copy). Falling edges generate nothing.
//   Output register (s, r, collision are registered, high exactly one cycle):
//     - rise_set only   -> s=1 next cycle;
//     - rise_reset only -> r=1 next cycle;
//     - both            -> collision=1, collision_cnt+1 (saturates at all-ones), and only the
//                          RESET_WINS winner pulses; the loser is dropped, not queued.
//   Latency: s (or r) is high after the (DEBOUNCE_CYCLES+3)-th rising edge at which the input is
//     sampled high, counting the first such edge as 1 (DEBOUNCE_CYCLES=4 gives 7).
//   Invariant: s & r == 0 in every cycle, including immediately after reset.
//   Held input: produces one pulse only; the next pulse needs a debounced low then a debounced high.
//   Input held high through reset release: treated as a new rising edge; one pulse after the
//     normal latency measured from release.
//   Reset mid-debounce or mid-pulse: the pending pulse is lost; s/r drop asynchronously.
//   Staggered edges (set debounced one cycle before reset): both pulse in consecutive cycles,
//     no collision counted.
// TESTING (DEBOUNCE_CYCLES=4, RESET_WINS=1, clk period 10)
//   1. set_in 0->1, held 100 -> s=1 for exactly one cycle, 7 edges after the first high sample;
//      set_db=1; r stays 0.
//   2. set_in high for 3 cycles, then low -> no s pulse; set_db stays 0.
//   3. set_in and reset_in rise together, held -> r single pulse; s=0 throughout; collision=1 for
//      one cycle; collision_cnt=1.
//   4. reset_in rises 1 cycle after set_in -> s pulse, then r pulse one cycle later;
//      collision_cnt unchanged.
//   5. rst pulsed mid-debounce of set_in (input held high) -> outputs 0 during rst; one s pulse
//      7 edges after release.
//   6. COLL_W=2 build, 5 collisions -> collision_cnt saturates at 3; s&r never both 1.
//   Every scenario: bench drives sr_using_d from s/r, checks q/qbar follow the commands, and
//   asserts the SR flop never sees s=r=1.

Source files
------------

// File: rtl/sr_cmd_conditioner.sv
// sr_cmd_conditioner: front end for the D-flop based SR flip-flop.
// Takes raw asynchronous set/reset requests and turns each one into a one-cycle
// s/r command. Each channel is synchronised, debounced and rising-edge detected.
// Simultaneous edges are arbitrated so that s and r are never high together.
// Channel index 0 is set and channel index 1 is reset.
module sr_cmd_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,  // >= 1
  parameter int CNT_W           = 3,  // 2**CNT_W must exceed DEBOUNCE_CYCLES
  parameter int COLL_W          = 8,
  parameter bit RESET_WINS      = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_in,
  input  logic              reset_in,
  output logic              s,
  output logic              r,
  output logic              set_db,
  output logic              reset_db,
  output logic              collision,
  output logic [COLL_W-1:0] collision_cnt
);

  localparam int NCH = 2;
  // The counter value seen on the edge that completes the debounce window.
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0]            w_raw;
  logic [NCH-1:0]            w_rise;
  logic                      w_both;
  logic [NCH-1:0]            r_sync1, r_sync2, r_db, r_db_d;
  logic [NCH-1:0][CNT_W-1:0] r_cnt;
  logic                      r_s, r_r, r_coll;
  logic [COLL_W-1:0]         r_coll_cnt;

  assign w_raw = {reset_in, set_in};

  // Two-flop synchroniser for each raw request line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: the debounced level follows the synchronised level only after
  // the two have disagreed for DEBOUNCE_CYCLES consecutive samples.
  // Any agreement restarts the window, so short glitches are rejected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db  <= '0;
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (r_sync2[i] != r_db[i]) begin
          if (r_cnt[i] == LP_LAST) begin
            r_db[i]  <= r_sync2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // Delayed copy of the debounced levels, used for rising-edge detection.
  // This copy clears on reset, so an input held high through reset release
  // is seen as a fresh rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_db_d <= '0;
    else     r_db_d <= r_db;
  end

  assign w_rise = r_db & ~r_db_d;
  assign w_both = &w_rise;

  // Registered command pulses. On a simultaneous edge only the configured
  // winner is issued; the loser is dropped, not queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_coll     <= 1'b0;
      r_coll_cnt <= '0;
    end else begin
      r_s    <= w_rise[0] & (~w_rise[1] | ~RESET_WINS);
      r_r    <= w_rise[1] & (~w_rise[0] |  RESET_WINS);
      r_coll <= w_both;
      if (w_both && (r_coll_cnt != '1))
        r_coll_cnt <= r_coll_cnt + 1'b1;
    end
  end

  assign s             = r_s;
  assign r             = r_r;
  assign set_db        = r_db[0];
  assign reset_db      = r_db[1];
  assign collision     = r_coll;
  assign collision_cnt = r_coll_cnt;

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Directed bench for sr_cmd_conditioner. Expected command pulses, with the
// cycle they are due, go into a scoreboard queue when stimulus is driven.
// A negedge monitor pops and compares them whenever the DUT pulses.
// A behavioural SR flop is driven from s/r so that q/qbar can be followed.
// A second DUT with a 2-bit collision counter shares the same inputs.
module tb_sr_cmd_conditioner;

  typedef struct {
    int   cyc;
    logic s;
    logic r;
    logic coll;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       set_in = 1'b0;
  logic       reset_in = 1'b0;
  logic       s, r, set_db, reset_db, collision;
  logic [7:0] collision_cnt;
  logic       s2, r2, set_db2, reset_db2, collision2;
  logic [1:0] collision_cnt2;
  logic       q;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];
  exp_t       e;

  sr_cmd_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .COLL_W(8), .RESET_WINS(1'b1)) dut (
    .clk(clk), .rst(rst), .set_in(set_in), .reset_in(reset_in),
    .s(s), .r(r), .set_db(set_db), .reset_db(reset_db),
    .collision(collision), .collision_cnt(collision_cnt)
  );

  sr_cmd_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .COLL_W(2), .RESET_WINS(1'b1)) dut2 (
    .clk(clk), .rst(rst), .set_in(set_in), .reset_in(reset_in),
    .s(s2), .r(r2), .set_db(set_db2), .reset_db(reset_db2),
    .collision(collision2), .collision_cnt(collision_cnt2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural stand-in for sr_using_d, fed from the command outputs.
  always @(posedge clk or posedge rst) begin
    if (rst)    q <= 1'b0;
    else if (s) q <= 1'b1;
    else if (r) q <= 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  // Monitor: the SR flop must never see s=r=1, and every pulse must match the
  // head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      chk("sr_never_both", {31'd0, s & r}, 32'd0);
      chk("sr_never_both_c2", {31'd0, s2 & r2}, 32'd0);
      if (s || r || collision) begin
        chk("pulse_expected", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("pulse_cycle", cyc, e.cyc);
          chk("pulse_s", {31'd0, s}, {31'd0, e.s});
          chk("pulse_r", {31'd0, r}, {31'd0, e.r});
          chk("pulse_coll", {31'd0, collision}, {31'd0, e.coll});
        end
      end
    end
  end

  task automatic push(input int c, input logic es, input logic er, input logic ec);
    exp_t x;
    x.cyc = c; x.s = es; x.r = er; x.coll = ec;
    sb.push_back(x);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // An expectation still queued after the scenario window means a missing pulse.
  task automatic sb_drained(input string tag);
    chk(tag, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    // Reset state.
    wait_cyc(3);
    chk("rst_s", {31'd0, s}, 0);
    chk("rst_r", {31'd0, r}, 0);
    chk("rst_set_db", {31'd0, set_db}, 0);
    chk("rst_reset_db", {31'd0, reset_db}, 0);
    chk("rst_coll", {31'd0, collision}, 0);
    chk("rst_coll_cnt", {24'd0, collision_cnt}, 0);
    chk("rst_coll_cnt2", {30'd0, collision_cnt2}, 0);
    rst = 1'b0;
    wait_cyc(2);

    // 1: clean set press, s pulse 7 edges after the first high sample.
    set_in = 1'b1;
    push(cyc + 7, 1'b1, 1'b0, 1'b0);
    wait_cyc(10);
    sb_drained("t1_sb");
    chk("t1_set_db", {31'd0, set_db}, 1);
    chk("t1_reset_db", {31'd0, reset_db}, 0);
    chk("t1_q", {31'd0, q}, 1);
    chk("t1_qbar", {31'd0, ~q}, 0);
    set_in = 1'b0;
    wait_cyc(10);
    chk("t1_set_db_low", {31'd0, set_db}, 0);

    // 2: 3-cycle glitch is rejected.
    set_in = 1'b1;
    wait_cyc(3);
    set_in = 1'b0;
    wait_cyc(10);
    chk("t2_set_db", {31'd0, set_db}, 0);
    sb_drained("t2_sb");

    // 3: simultaneous edges, reset wins and a collision is counted.
    set_in = 1'b1; reset_in = 1'b1;
    push(cyc + 7, 1'b0, 1'b1, 1'b1);
    wait_cyc(10);
    sb_drained("t3_sb");
    chk("t3_coll_cnt", {24'd0, collision_cnt}, 1);
    chk("t3_coll_cnt2", {30'd0, collision_cnt2}, 1);
    chk("t3_q", {31'd0, q}, 0);
    chk("t3_qbar", {31'd0, ~q}, 1);
    set_in = 1'b0; reset_in = 1'b0;
    wait_cyc(10);

    // 4: staggered edges give s then r, with no collision.
    set_in = 1'b1;
    push(cyc + 7, 1'b1, 1'b0, 1'b0);
    wait_cyc(1);
    reset_in = 1'b1;
    push(cyc + 7, 1'b0, 1'b1, 1'b0);
    wait_cyc(10);
    sb_drained("t4_sb");
    chk("t4_coll_cnt", {24'd0, collision_cnt}, 1);
    chk("t4_q", {31'd0, q}, 0);
    set_in = 1'b0; reset_in = 1'b0;
    wait_cyc(10);

    // 5: reset pulsed mid-debounce while set is held high.
    set_in = 1'b1;
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(1);
    chk("t5_rst_s", {31'd0, s}, 0);
    chk("t5_rst_set_db", {31'd0, set_db}, 0);
    wait_cyc(1);
    rst = 1'b0;
    push(cyc + 7, 1'b1, 1'b0, 1'b0);
    wait_cyc(10);
    sb_drained("t5_sb");
    chk("t5_q", {31'd0, q}, 1);
    chk("t5_coll_cnt", {24'd0, collision_cnt}, 0);
    set_in = 1'b0;
    wait_cyc(10);

    // 6: five collisions; the 2-bit counter saturates at 3.
    for (int k = 1; k <= 5; k++) begin
      set_in = 1'b1; reset_in = 1'b1;
      push(cyc + 7, 1'b0, 1'b1, 1'b1);
      wait_cyc(10);
      sb_drained("t6_sb");
      chk("t6_coll_cnt", {24'd0, collision_cnt}, k);
      chk("t6_coll_cnt2", {30'd0, collision_cnt2}, (k > 3) ? 3 : k);
      set_in = 1'b0; reset_in = 1'b0;
      wait_cyc(10);
    end
    chk("t6_q", {31'd0, q}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
